// File: rtl/vp_centroid_overlay.sv
// rtl/vp_centroid_overlay.sv - per-frame mask centroid with cross-marker overlay; optional bbox via VP_CENTROID_BBOX_EN
module vp_centroid_overlay #(
   parameter int          X_W        = 11,
   parameter int          Y_W        = 11,
   parameter int          ARM        = 10,
   parameter logic [23:0] MARK_COLOR = 24'hFF0000,
   parameter int          MIN_PIXELS = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           de_in,
   input  logic           h_sync_in,
   input  logic           v_sync_in,
   input  logic [23:0]    pixel_in,
   input  logic           mask_in,
   input  logic           overlay_en,
   output logic           de_out,
   output logic           h_sync_out,
   output logic           v_sync_out,
   output logic [23:0]    pixel_out,
   output logic [X_W-1:0] centroid_x,
   output logic [Y_W-1:0] centroid_y,
   output logic           centroid_valid,
`ifdef VP_CENTROID_BBOX_EN
   output logic [X_W-1:0] bbox_xmin,
   output logic [X_W-1:0] bbox_xmax,
   output logic [Y_W-1:0] bbox_ymin,
   output logic [Y_W-1:0] bbox_ymax,
`endif
   output logic           overrun
);

   localparam int N_W  = X_W + Y_W;
   localparam int MX_W = X_W + N_W;
   localparam int MY_W = Y_W + N_W;
   localparam int R_W  = (MX_W > MY_W) ? MX_W : MY_W;
   localparam int C_W  = $clog2(R_W) + 1;
   localparam logic [X_W-1:0] ARM_X = X_W'(ARM);
   localparam logic [Y_W-1:0] ARM_Y = Y_W'(ARM);

   typedef enum logic [2:0] {IDLE, CHECK, DIV_X, DIV_Y, UPDATE} state_t;

   state_t          state;
   logic [X_W-1:0]  x_cnt;
   logic [Y_W-1:0]  y_cnt;
   logic [N_W-1:0]  m00, s_m00;
   logic [MX_W-1:0] m10, s_m10;
   logic [MY_W-1:0] m01, s_m01;
   logic [R_W-1:0]  rem, dvs;
   logic [C_W-1:0]  cnt;
   logic [X_W-1:0]  q_x, dx;
   logic [Y_W-1:0]  q_y, dy;
   logic            hit, mark;
   logic            vs_rise, de_fall;

   // The delayed de/vsync registers double as the previous-cycle values for edge detection
   assign vs_rise = v_sync_in & ~v_sync_out;
   assign de_fall = de_out & ~de_in;

   // Pixel position of the current input sample
   always_ff @(posedge clk) begin
      if (rst) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         x_cnt <= de_in ? x_cnt + X_W'(1) : '0;
         if (vs_rise)
            y_cnt <= '0;
         else if (de_fall)
            y_cnt <= y_cnt + Y_W'(1);
      end
   end

   // Moment accumulators; frame end clears them whether or not the divider took a snapshot
   always_ff @(posedge clk) begin
      if (rst || vs_rise) begin
         m00 <= '0;
         m10 <= '0;
         m01 <= '0;
      end else if (de_in && mask_in) begin
         m00 <= m00 + N_W'(1);
         m10 <= m10 + MX_W'(x_cnt);
         m01 <= m01 + MY_W'(y_cnt);
      end
   end

`ifdef VP_CENTROID_BBOX_EN
   logic [X_W-1:0] bx_lo, bx_hi, sx_lo, sx_hi;
   logic [Y_W-1:0] by_lo, by_hi, sy_lo, sy_hi;

   // Running extent of mask pixels in the current frame
   always_ff @(posedge clk) begin
      if (rst || vs_rise) begin
         bx_lo <= '1;
         bx_hi <= '0;
         by_lo <= '1;
         by_hi <= '0;
      end else if (de_in && mask_in) begin
         if (x_cnt < bx_lo) bx_lo <= x_cnt;
         if (x_cnt > bx_hi) bx_hi <= x_cnt;
         if (y_cnt < by_lo) by_lo <= y_cnt;
         if (y_cnt > by_hi) by_hi <= y_cnt;
      end
   end
`endif

   // Snapshot, validity check, two restoring divisions and centroid update
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         s_m00          <= '0;
         s_m10          <= '0;
         s_m01          <= '0;
         rem            <= '0;
         dvs            <= '0;
         cnt            <= '0;
         q_x            <= '0;
         q_y            <= '0;
         centroid_x     <= '0;
         centroid_y     <= '0;
         centroid_valid <= 1'b0;
         overrun        <= 1'b0;
`ifdef VP_CENTROID_BBOX_EN
         sx_lo     <= '0;
         sx_hi     <= '0;
         sy_lo     <= '0;
         sy_hi     <= '0;
         bbox_xmin <= '0;
         bbox_xmax <= '0;
         bbox_ymin <= '0;
         bbox_ymax <= '0;
`endif
      end else begin
         if (vs_rise && state != IDLE)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (vs_rise) begin
                  s_m00 <= m00;
                  s_m10 <= m10;
                  s_m01 <= m01;
`ifdef VP_CENTROID_BBOX_EN
                  sx_lo <= bx_lo;
                  sx_hi <= bx_hi;
                  sy_lo <= by_lo;
                  sy_hi <= by_hi;
`endif
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (s_m00 < N_W'(MIN_PIXELS)) begin
                  centroid_valid <= 1'b0;
                  state          <= IDLE;
               end else begin
                  // Divisor starts aligned to the quotient MSB; the mean always fits X_W bits
                  rem   <= R_W'(s_m10);
                  dvs   <= R_W'(s_m00) << (X_W - 1);
                  cnt   <= C_W'(X_W - 1);
                  state <= DIV_X;
               end
            end
            DIV_X: begin
               if (rem >= dvs) begin
                  rem <= rem - dvs;
                  q_x <= {q_x[X_W-2:0], 1'b1};
               end else begin
                  q_x <= {q_x[X_W-2:0], 1'b0};
               end
               dvs <= dvs >> 1;
               cnt <= cnt - C_W'(1);
               if (cnt == '0) begin
                  rem   <= R_W'(s_m01);
                  dvs   <= R_W'(s_m00) << (Y_W - 1);
                  cnt   <= C_W'(Y_W - 1);
                  state <= DIV_Y;
               end
            end
            DIV_Y: begin
               if (rem >= dvs) begin
                  rem <= rem - dvs;
                  q_y <= {q_y[Y_W-2:0], 1'b1};
               end else begin
                  q_y <= {q_y[Y_W-2:0], 1'b0};
               end
               dvs <= dvs >> 1;
               cnt <= cnt - C_W'(1);
               if (cnt == '0)
                  state <= UPDATE;
            end
            UPDATE: begin
               centroid_x     <= q_x;
               centroid_y     <= q_y;
               centroid_valid <= 1'b1;
`ifdef VP_CENTROID_BBOX_EN
               bbox_xmin <= sx_lo;
               bbox_xmax <= sx_hi;
               bbox_ymin <= sy_lo;
               bbox_ymax <= sy_hi;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Marker hit test on the current input position; unsigned distances clip the arms at edges
   always_comb begin
      dx  = (x_cnt >= centroid_x) ? x_cnt - centroid_x : centroid_x - x_cnt;
      dy  = (y_cnt >= centroid_y) ? y_cnt - centroid_y : centroid_y - y_cnt;
      hit = ((x_cnt == centroid_x) && (dy <= ARM_Y)) ||
            ((y_cnt == centroid_y) && (dx <= ARM_X));
`ifdef VP_CENTROID_BBOX_EN
      hit = hit ||
            (((x_cnt == bbox_xmin) || (x_cnt == bbox_xmax)) &&
             (y_cnt >= bbox_ymin) && (y_cnt <= bbox_ymax)) ||
            (((y_cnt == bbox_ymin) || (y_cnt == bbox_ymax)) &&
             (x_cnt >= bbox_xmin) && (x_cnt <= bbox_xmax));
`endif
      mark = overlay_en & centroid_valid & de_in & hit;
   end

   // One-cycle output stage keeping syncs aligned with the overlaid pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         de_out     <= 1'b0;
         h_sync_out <= 1'b0;
         v_sync_out <= 1'b0;
         pixel_out  <= '0;
      end else begin
         de_out     <= de_in;
         h_sync_out <= h_sync_in;
         v_sync_out <= v_sync_in;
         pixel_out  <= mark ? MARK_COLOR : pixel_in;
      end
   end

endmodule

// File: tb/tb_vp_centroid_overlay.sv
// tb/tb_vp_centroid_overlay.sv - testbench for vp_centroid_overlay
module tb_vp_centroid_overlay;

   localparam int W = 64;
   localparam int H = 48;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
   logic [23:0] pixel_in = '0;
   logic        mask_in = 1'b0, overlay_en = 1'b0;
   logic        de_out, h_sync_out, v_sync_out;
   logic [23:0] pixel_out;
   logic [10:0] centroid_x, centroid_y;
   logic        centroid_valid, overrun;

   vp_centroid_overlay #(.X_W(11), .Y_W(11), .ARM(3), .MARK_COLOR(24'hFF0000), .MIN_PIXELS(16)) dut (
      .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .pixel_in(pixel_in), .mask_in(mask_in), .overlay_en(overlay_en),
      .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .pixel_out(pixel_out),
      .centroid_x(centroid_x), .centroid_y(centroid_y), .centroid_valid(centroid_valid),
      .overrun(overrun));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { int cyc; logic de; logic hs; logic vs; logic [23:0] px; } sb_t;
   sb_t sb[$];

   typedef struct { int mode; logic ov; int ex; int ey; logic ev; } vec_t;
   vec_t vecs[7];
   vec_t exp_q[$];

   int   m_cx = 0, m_cy = 0;
   logic m_valid = 1'b0;

   function automatic logic mask_at(int mode, int x, int y);
      case (mode)
         0: return (x >= 4 && x <= 7 && y >= 2 && y <= 5);
         1: return (x >= 4 && x <= 7 && y >= 2 && y <= 5) && !(x == 7 && y == 5);
         2: return (x >= 29 && x <= 32 && y >= 19 && y <= 22);
         3: return (y == 10 && x < 16);
         4: return (y == 47 && x >= 48);
         5: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic mark_at(int x, int y);
      int dx, dy;
      dx = (x > m_cx) ? x - m_cx : m_cx - x;
      dy = (y > m_cy) ? y - m_cy : m_cy - y;
      return overlay_en && m_valid && ((x == m_cx && dy <= 3) || (y == m_cy && dx <= 3));
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic drive(input logic d, input logic hs, input logic vs, input logic mk,
                        input int x, input int y, input logic r);
      sb_t e;
      @(posedge clk);
      #1;
      rst = r; de_in = d; h_sync_in = hs; v_sync_in = vs; mask_in = mk;
      pixel_in = 24'($urandom);
      if (r) begin
         m_valid = 1'b0;
         m_cx = 0;
         m_cy = 0;
      end
      e.cyc = cyc;
      if (r) begin
         e.de = 1'b0; e.hs = 1'b0; e.vs = 1'b0; e.px = '0;
      end else begin
         e.de = d; e.hs = hs; e.vs = vs;
         e.px = (d && mark_at(x, y)) ? 24'hFF0000 : pixel_in;
      end
      sb.push_back(e);
   endtask

   task automatic send_frame(input int mode);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) drive(1'b1, 1'b0, 1'b0, mask_at(mode, x, y), x, y, 1'b0);
         for (int h = 0; h < 8; h++) drive(1'b0, (h >= 2 && h < 6), 1'b0, 1'b0, 0, y, 1'b0);
      end
   endtask

   task automatic vblank(input logic extra_rise);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      if (extra_rise) begin
         repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
         repeat (2) drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      end
      repeat (40) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic chk_centroid(input string tag, input int ex, input int ey, input logic ev,
                               input logic eo);
      chk({tag, "_x"}, int'(centroid_x), ex);
      chk({tag, "_y"}, int'(centroid_y), ey);
      chk({tag, "_valid"}, int'(centroid_valid), int'(ev));
      chk({tag, "_overrun"}, int'(overrun), int'(eo));
   endtask

   // Stream scoreboard: each driven cycle must reappear on the outputs one clock later
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
         sb_t e;
         e = sb.pop_front();
         checks++;
         if ({de_out, h_sync_out, v_sync_out, pixel_out} !== {e.de, e.hs, e.vs, e.px}) begin
            errors++;
            $display("FAIL stream cyc=%0d got de=%0b hs=%0b vs=%0b px=%06h exp de=%0b hs=%0b vs=%0b px=%06h",
                     cyc, de_out, h_sync_out, v_sync_out, pixel_out, e.de, e.hs, e.vs, e.px);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t v;
      vecs[0] = '{mode: 0, ov: 1'b1, ex: 5,  ey: 3,  ev: 1'b1};
      vecs[1] = '{mode: 1, ov: 1'b1, ex: 5,  ey: 3,  ev: 1'b0};
      vecs[2] = '{mode: 2, ov: 1'b1, ex: 30, ey: 20, ev: 1'b1};
      vecs[3] = '{mode: 3, ov: 1'b1, ex: 7,  ey: 10, ev: 1'b1};
      vecs[4] = '{mode: 4, ov: 1'b0, ex: 55, ey: 47, ev: 1'b1};
      vecs[5] = '{mode: 5, ov: 1'b1, ex: 31, ey: 23, ev: 1'b1};
      vecs[6] = '{mode: 6, ov: 1'b1, ex: 31, ey: 23, ev: 1'b0};

      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk_centroid("reset", 0, 0, 1'b0, 1'b0);

      for (int i = 0; i < 7; i++) begin
         overlay_en = vecs[i].ov;
         send_frame(vecs[i].mode);
         exp_q.push_back(vecs[i]);
         vblank(1'b0);
         @(negedge clk);
         v = exp_q.pop_front();
         chk_centroid($sformatf("frame%0d", i), v.ex, v.ey, v.ev, 1'b0);
         if (v.ev) begin
            m_cx = v.ex;
            m_cy = v.ey;
         end
         m_valid = v.ev;
      end

      // Second frame end five cycles after the first lands while the divider is busy
      overlay_en = 1'b1;
      send_frame(2);
      vblank(1'b1);
      @(negedge clk);
      chk_centroid("overrun", 30, 20, 1'b1, 1'b1);
      m_cx = 30; m_cy = 20; m_valid = 1'b1;

      // Reset lands while the divider is in DIV_X
      send_frame(0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk_centroid("rst_mid_div", 0, 0, 1'b0, 1'b0);
      repeat (40) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      chk_centroid("rst_no_update", 0, 0, 1'b0, 1'b0);

      send_frame(0);
      vblank(1'b0);
      @(negedge clk);
      chk_centroid("after_rst", 5, 3, 1'b1, 1'b0);

      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
